// File: rtl/lenet_pkg.sv
// Shared LeNet constants: map/window geometry, C3 window-generator state encoding
// and the flat window element index used on the window bus.
package lenet_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int MAP_DIM    = 14;
  localparam int WIN        = 5;
  localparam int OUT_DIM    = MAP_DIM - WIN + 1;
  localparam int CHANNELS   = 6;

  // Width of the per-column fetch counter and the loaded-column counter (0..WIN).
  localparam int CNT_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic int unsigned idx(input int unsigned ch, input int unsigned wr,
                                      input int unsigned wc);
    return ch * WIN * WIN + wr * WIN + wc;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// One channel's WxW window: rows 0..W-2 of the incoming column are staged, and on
// shift the window moves left one column with the staged rows plus cap_data entering at wc=W-1.
module window_shift_reg
  import lenet_pkg::*;
#(
  parameter int DW = 12,
  parameter int W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 cap_en,
  input  logic [CNT_W-1:0]     cap_row,
  input  logic [DW-1:0]        cap_data,
  input  logic                 shift_en,
  output logic [W*W*DW-1:0]    win
);

  logic [DW-1:0] win_q [W][W];
  logic [DW-1:0] col_q [W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int wr = 0; wr < W; wr++)
        for (int wc = 0; wc < W; wc++)
          win_q[wr][wc] <= '0;
      for (int r = 0; r < W - 1; r++)
        col_q[r] <= '0;
    end else if (clr) begin
      for (int wr = 0; wr < W; wr++)
        for (int wc = 0; wc < W; wc++)
          win_q[wr][wc] <= '0;
      for (int r = 0; r < W - 1; r++)
        col_q[r] <= '0;
    end else begin
      for (int r = 0; r < W - 1; r++)
        if (cap_en && (cap_row == CNT_W'(r)))
          col_q[r] <= cap_data;
      if (shift_en) begin
        for (int wr = 0; wr < W; wr++)
          for (int wc = 0; wc < W - 1; wc++)
            win_q[wr][wc] <= win_q[wr][wc+1];
        for (int r = 0; r < W - 1; r++)
          win_q[r][W-1] <= col_q[r];
        // The bottom row arrives on the same cycle as the shift, straight from memory.
        win_q[W-1][W-1] <= cap_data;
      end
    end
  end

  for (genvar wr = 0; wr < W; wr++) begin : g_row
    for (genvar wc = 0; wc < W; wc++) begin : g_col
      assign win[(wr*W + wc)*DW +: DW] = win_q[wr][wc];
    end
  end

endmodule

// File: rtl/mid_layer_window_gen.sv
// Builds every 5x5x6 window over the six pooled maps in raster order, one column of
// five reads at a time, and hands each window to C3 over a valid/ready handshake.
module mid_layer_window_gen #(
  parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
  parameter int MAP_DIM    = lenet_pkg::MAP_DIM,
  parameter int WIN        = lenet_pkg::WIN,
  parameter int OUT_DIM    = lenet_pkg::OUT_DIM,
  parameter int CHANNELS   = lenet_pkg::CHANNELS,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  rd_en,
  output logic [ADDR_WIDTH-1:0]                 rd_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0]        rd_data,
  output logic [CHANNELS*WIN*WIN*DATA_WIDTH-1:0] win_data,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic [3:0]                            out_row,
  output logic [3:0]                            out_col,
  output logic                                  done,
  output logic [1:0]                            state_dbg
);
  import lenet_pkg::*;

  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(WIN);
  localparam logic [3:0]       C_LAST = 4'(MAP_DIM);
  localparam logic [3:0]       R_LAST = 4'(OUT_DIM - 1);
  localparam logic [3:0]       W4     = 4'(WIN);

  logic [1:0]            state;
  logic [3:0]            r0;
  logic [3:0]            c;
  logic [CNT_W-1:0]      f;
  logic [CNT_W-1:0]      loaded;
  logic [CNT_W-1:0]      loaded_inc;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic                  cap_en;
  logic                  shift_en;
  logic                  clr;
  logic [CNT_W-1:0]      cap_row;

  assign loaded_inc = (loaded >= F_LAST) ? F_LAST : loaded + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      r0     <= '0;
      c      <= '0;
      f      <= '0;
      loaded <= '0;
    end else if (!start) begin
      state  <= ST_IDLE;
      r0     <= '0;
      c      <= '0;
      f      <= '0;
      loaded <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state  <= ST_FETCH;
          r0     <= '0;
          c      <= '0;
          f      <= '0;
          loaded <= '0;
        end
        ST_FETCH: begin
          if (f == F_LAST) begin
            f      <= '0;
            c      <= c + 4'd1;
            loaded <= loaded_inc;
            if (loaded_inc >= F_LAST)
              state <= ST_PRESENT;
          end else begin
            f <= f + 1'b1;
          end
        end
        ST_PRESENT: begin
          if (win_ready) begin
            if (c == C_LAST) begin
              if (r0 == R_LAST) begin
                state <= ST_DONE;
              end else begin
                r0     <= r0 + 4'd1;
                c      <= '0;
                loaded <= '0;
                state  <= ST_FETCH;
              end
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

  // Reads go out for f=0..WIN-1; each returns one cycle later and lands in row f-1.
  assign row_addr  = ADDR_WIDTH'(r0) + ADDR_WIDTH'(f);
  assign addr_calc = ADDR_WIDTH'(row_addr * ADDR_WIDTH'(MAP_DIM)) + ADDR_WIDTH'(c);
  assign rd_en     = (state == ST_FETCH) && (f < F_LAST);
  assign rd_addr   = rd_en ? addr_calc : '0;

  assign cap_en   = (state == ST_FETCH) && (f != '0) && (f != F_LAST);
  assign cap_row  = f - 1'b1;
  assign shift_en = (state == ST_FETCH) && (f == F_LAST);
  assign clr      = !start;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    window_shift_reg #(
      .DW (DATA_WIDTH),
      .W  (WIN)
    ) u_win (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .cap_en   (cap_en),
      .cap_row  (cap_row),
      .cap_data (rd_data[ch*DATA_WIDTH +: DATA_WIDTH]),
      .shift_en (shift_en),
      .win      (win_data[ch*WIN*WIN*DATA_WIDTH +: WIN*WIN*DATA_WIDTH])
    );
  end

  // Handshake: a window transfers on a clock edge with win_valid && win_ready; while
  // win_valid && !win_ready, win_data/out_row/out_col hold and no reads are issued.
  assign win_valid = (state == ST_PRESENT);
  assign done      = (state == ST_DONE);
  assign out_row   = win_valid ? r0 : 4'd0;
  assign out_col   = win_valid ? (c - W4) : 4'd0;
  assign state_dbg = state;

endmodule
